// File: rtl/image_window_compute_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : image_window_compute_ctrl_pkg
//  Description : Shared constants, FSM state encoding and helpers for the
//                3x3 conv front end (row FIFOs + compute sequencer).
//  Revision    : 1.0 - initial release
// ============================================================================
package image_window_compute_ctrl_pkg;

    localparam int KERNEL_NUM    = 9;   // taps, one row FIFO each
    localparam int DATA_WIDTH    = 32;  // PICTURE_NUM*8 bits per tap word
    localparam int WEIGHT_WORDS  = 33;  // weight RAM words read per load
    localparam int SETTLE_CYCLES = 2;   // RAM read latency slack after load
    localparam int ROW_BITS      = 11;  // width of the row/column counters

    localparam logic [3:0] GROUP_SEL_0 = 4'b0001;
    localparam logic [3:0] GROUP_SEL_1 = 4'b0010;
    localparam logic [3:0] GROUP_SEL_2 = 4'b0100;
    localparam logic [3:0] GROUP_SEL_3 = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_W   = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_WAIT_ROW = 3'd3,
        ST_COMPUTE  = 3'd4,
        ST_DRAIN    = 3'd5
    } state_t;

    // Weight groups per pixel: one group per 8 output channels, kept in 1..4.
    function automatic logic [2:0] group_count(input logic [7:0] channels);
        logic [4:0] g;
        g = channels[7:3];
        if (g == 5'd0)
            return 3'd1;
        else if (g > 5'd4)
            return 3'd4;
        else
            return g[2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/image_window_compute_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : image_window_compute_ctrl_if
//  Description : Bundle of the control, tap-stream, weight-RAM and output
//                flag signals of image_window_compute_ctrl.
//                slave  : the controller's view (drives FIFO data and flags)
//                master : the surrounding system's view
//  Revision    : 1.0 - initial release
// ============================================================================
interface image_window_compute_ctrl_if
    import image_window_compute_ctrl_pkg::*;
#(
    parameter int WIDTH_RAM_ADDR_SIZE = 6
);
    logic                             Start;
    logic [ROW_BITS-1:0]              Row_Num_Out_REG;
    logic [7:0]                       Channel_Out_Num_REG;
    logic [KERNEL_NUM-1:0]            S_Valid;
    logic [KERNEL_NUM*DATA_WIDTH-1:0] S_Feature;
    logic                             S_Ready;
    logic                             M_Ready;
    logic [KERNEL_NUM*DATA_WIDTH-1:0] fifo_out_data;
    logic                             rd_en_fifo;
    logic [WIDTH_RAM_ADDR_SIZE-1:0]   weight_addrb;
    logic [3:0]                       weight_select;
    logic                             M_Valid;
    logic                             Compute_Complete;
    logic                             Conv_Complete;

    modport slave (
        input  Start, Row_Num_Out_REG, Channel_Out_Num_REG, S_Valid, S_Feature, M_Ready,
        output S_Ready, fifo_out_data, rd_en_fifo, weight_addrb, weight_select,
               M_Valid, Compute_Complete, Conv_Complete
    );

    modport master (
        output Start, Row_Num_Out_REG, Channel_Out_Num_REG, S_Valid, S_Feature, M_Ready,
        input  S_Ready, fifo_out_data, rd_en_fifo, weight_addrb, weight_select,
               M_Valid, Compute_Complete, Conv_Complete
    );
endinterface
`default_nettype wire

// File: rtl/image_window_compute_ctrl_row_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : image_row_fifo
//  Description : Count-based synchronous FIFO holding one kernel tap stream.
//                Registered read data (valid the cycle after rd_en).
//  Ports       : clk, rst (sync, active-low)
//                wr_en/din      push side, dropped when full
//                rd_en/dout     pop side, ignored when empty
//                m_count/m_ready  m_ready = count >= m_count
//                s_count/s_ready  s_ready = free slots >= s_count
//  Revision    : 1.0 - initial release
// ============================================================================
module image_row_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 10,
    parameter int THR_BITS   = 11
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  wr_en,
    input  wire logic [DATA_WIDTH-1:0] din,
    input  wire logic                  rd_en,
    output logic      [DATA_WIDTH-1:0] dout,
    input  wire logic [THR_BITS-1:0]   m_count,
    input  wire logic [THR_BITS-1:0]   s_count,
    output logic                       m_ready,
    output logic                       s_ready
);
    localparam int CNT_W = ADDR_BITS + 1;
    localparam int CMP_W = (CNT_W > THR_BITS) ? CNT_W : THR_BITS;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(1 << ADDR_BITS);

    logic [DATA_WIDTH-1:0] r_mem [1 << ADDR_BITS];
    logic [ADDR_BITS-1:0]  r_wr_ptr;
    logic [ADDR_BITS-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_do_wr;
    logic                  w_do_rd;

    assign w_do_wr = wr_en && (r_count != c_depth);
    assign w_do_rd = rd_en && (r_count != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            dout     <= '0;
        end else begin
            if (w_do_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                dout     <= r_mem[r_rd_ptr];
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is left without reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_do_wr)
            r_mem[r_wr_ptr] <= din;
    end

    assign m_ready = CMP_W'(r_count) >= CMP_W'(m_count);
    assign s_ready = CMP_W'(c_depth - r_count) >= CMP_W'(s_count);

endmodule
`default_nettype wire

// File: rtl/image_window_compute_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : image_window_compute_ctrl
//  Description : Front end of the 3x3 conv engine. Nine tap FIFOs plus the
//                sequencer that loads weights, then streams each output row
//                pixel by pixel, cycling 1..4 weight groups per pixel.
//  Ports       : clk, rst (sync, active-low)
//                bus (slave)  Start / row + channel config / tap stream in,
//                             FIFO data, pop strobe, weight RAM address,
//                             group select and completion flags out
//  Revision    : 1.0 - initial release
// ============================================================================
module image_window_compute_ctrl
    import image_window_compute_ctrl_pkg::*;
#(
    parameter int ADDR_BITS           = 10,
    parameter int WIDTH_RAM_ADDR_SIZE = 6,
    parameter int PIPE_LAT            = 6
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    image_window_compute_ctrl_if.slave bus
);
    localparam int CNT_W = 8;
    localparam logic [WIDTH_RAM_ADDR_SIZE-1:0] c_last_addr =
        WIDTH_RAM_ADDR_SIZE'(WEIGHT_WORDS - 1);

    state_t                           r_state;
    state_t                           w_next;
    logic [WIDTH_RAM_ADDR_SIZE-1:0]   r_addr;
    logic [CNT_W-1:0]                 r_cnt;
    logic [ROW_BITS-1:0]              r_row;
    logic [ROW_BITS-1:0]              r_col;
    logic [1:0]                       r_grp;
    logic [PIPE_LAT-1:0]              r_valid_sr;

    logic [KERNEL_NUM*DATA_WIDTH-1:0] w_dout;
    logic [KERNEL_NUM-1:0]            w_m_ready;
    logic [KERNEL_NUM-1:0]            w_s_ready;
    logic [ROW_BITS-1:0]              w_rows;
    logic [2:0]                       w_groups;
    logic                             w_last_grp;
    logic                             w_last_col;
    logic                             w_last_row;
    logic                             w_rd_en;
    logic [3:0]                       w_wsel;
    logic                             w_row_done;
    logic                             w_conv_done;

    assign w_rows     = bus.Row_Num_Out_REG;
    assign w_groups   = group_count(bus.Channel_Out_Num_REG);
    assign w_last_grp = ({1'b0, r_grp} + 3'd1) == w_groups;
    assign w_last_col = r_col == (w_rows - 1'b1);
    assign w_last_row = ({1'b0, r_row} + 1'b1) >= {1'b0, w_rows};

    // ------------------------------------------------------------------
    // Tap FIFOs; all taps are written in lockstep so tap 0 speaks for all.
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < KERNEL_NUM; i++) begin : g_tap
            image_row_fifo #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_BITS  (ADDR_BITS),
                .THR_BITS   (ROW_BITS)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .wr_en   (bus.S_Valid[i]),
                .din     (bus.S_Feature[i*DATA_WIDTH +: DATA_WIDTH]),
                .rd_en   (w_rd_en),
                .dout    (w_dout[i*DATA_WIDTH +: DATA_WIDTH]),
                .m_count (w_rows),
                .s_count (w_rows),
                .m_ready (w_m_ready[i]),
                .s_ready (w_s_ready[i])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_rd_en     = 1'b0;
        w_wsel      = GROUP_SEL_0;
        w_row_done  = 1'b0;
        w_conv_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.Start)
                    w_next = ST_LOAD_W;
            end
            ST_LOAD_W: begin
                if (r_addr == c_last_addr)
                    w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    // An empty image has nothing to compute or drain.
                    if (w_rows == '0) begin
                        w_conv_done = 1'b1;
                        w_next      = ST_IDLE;
                    end else begin
                        w_next = ST_WAIT_ROW;
                    end
                end
            end
            ST_WAIT_ROW: begin
                if (w_m_ready[0] && bus.M_Ready)
                    w_next = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                w_wsel  = GROUP_SEL_0 << r_grp;
                w_rd_en = (r_grp == 2'd0);
                if (w_last_grp && w_last_col) begin
                    w_row_done = 1'b1;
                    w_next     = w_last_row ? ST_DRAIN : ST_WAIT_ROW;
                end
            end
            ST_DRAIN: begin
                // Held one cycle past PIPE_LAT so the last M_Valid is out first.
                if (r_cnt == CNT_W'(PIPE_LAT)) begin
                    w_conv_done = 1'b1;
                    w_next      = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Counters: r_cnt restarts on every state change (settle / drain timing).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr     <= '0;
            r_cnt      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_grp      <= '0;
            r_valid_sr <= '0;
        end else begin
            r_cnt      <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            r_valid_sr <= {r_valid_sr[PIPE_LAT-2:0], (r_state == ST_COMPUTE)};
            case (r_state)
                ST_IDLE: begin
                    r_addr <= '0;
                    r_row  <= '0;
                    r_col  <= '0;
                    r_grp  <= '0;
                end
                ST_LOAD_W: begin
                    r_addr <= (r_addr == c_last_addr) ? '0 : r_addr + 1'b1;
                end
                ST_COMPUTE: begin
                    if (w_last_grp) begin
                        r_grp <= '0;
                        if (w_last_col) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end else begin
                        r_grp <= r_grp + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.fifo_out_data    = w_dout;
    assign bus.S_Ready          = w_s_ready[0];
    assign bus.rd_en_fifo       = w_rd_en;
    assign bus.weight_addrb     = r_addr;
    assign bus.weight_select    = w_wsel;
    assign bus.M_Valid          = r_valid_sr[PIPE_LAT-1];
    assign bus.Compute_Complete = w_row_done;
    assign bus.Conv_Complete    = w_conv_done;

endmodule
`default_nettype wire

// File: tb/tb_image_window_compute_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_image_window_compute_ctrl
//  Description : Directed self-checking bench for image_window_compute_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_image_window_compute_ctrl;
    import image_window_compute_ctrl_pkg::*;

    localparam int NT    = KERNEL_NUM;
    localparam int DW    = DATA_WIDTH;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    image_window_compute_ctrl_if bus ();

    image_window_compute_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int passed = 0;
    int total  = 0;

    // Expected FIFO contents (sequence numbers) and the word owed next cycle.
    int q[$];
    int pend_seq;
    bit pend     = 1'b0;
    int seq_next = 0;

    int n_rd, n_mv, n_cc, n_conv, ws_bad, data_bad;
    int first_rd, last_rd, first_mv, last_mv;
    bit done;

    function automatic logic [NT*DW-1:0] mk_word(input int s);
        logic [NT*DW-1:0] v;
        logic [23:0]      s24;
        s24 = s[23:0];
        for (int i = 0; i < NT; i++)
            v[i*DW +: DW] = {s24, 8'(i)};
        return v;
    endfunction

    // mode 0: run max_cycles; mode 1: stop after Conv_Complete; mode 2: stop after first rd_en
    task automatic run_image(input int max_cycles, input int mode, input int n_push, input int groups);
        int ph;
        int sz;
        int pushes;
        ph = 0; pushes = n_push;
        n_rd = 0; n_mv = 0; n_cc = 0; n_conv = 0; ws_bad = 0; data_bad = 0;
        first_rd = -1; last_rd = -1; first_mv = -1; last_mv = -1; done = 1'b0;
        for (int t = 0; t < max_cycles; t++) begin
            if (pend) begin
                if (bus.fifo_out_data !== mk_word(pend_seq)) data_bad++;
                pend = 1'b0;
            end
            if (bus.rd_en_fifo) begin
                n_rd++;
                if (first_rd < 0) first_rd = t;
                last_rd = t;
                if (bus.weight_select !== 4'b0001) ws_bad++;
                if (ph > 0 && ph < groups) ws_bad++;
                ph = 1;
            end else if (ph > 0 && ph < groups) begin
                if (bus.weight_select !== 4'(1 << ph)) ws_bad++;
                ph++;
            end
            if (bus.M_Valid) begin
                n_mv++;
                if (first_mv < 0) first_mv = t;
                last_mv = t;
            end
            if (bus.Compute_Complete) n_cc++;
            if (bus.Conv_Complete) n_conv++;
            if ((mode == 1 && bus.Conv_Complete) || (mode == 2 && bus.rd_en_fifo)) done = 1'b1;
            sz = q.size();
            if (bus.rd_en_fifo && sz > 0) begin
                pend_seq = q.pop_front();
                pend     = 1'b1;
            end
            if (pushes > 0) begin
                if (sz < DEPTH) q.push_back(seq_next);
                bus.S_Valid   = '1;
                bus.S_Feature = mk_word(seq_next);
                seq_next++;
                pushes--;
            end else begin
                bus.S_Valid = '0;
            end
            @(negedge clk);
            if (done) break;
        end
        bus.S_Valid = '0;
    endtask

    task automatic pulse_start();
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.rd_en_fifo !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", bus.rd_en_fifo); else passed++;
        total++; if (bus.weight_addrb !== 6'd0) $display("FAIL reset_addr: got %0d want 0", bus.weight_addrb); else passed++;
        total++; if (bus.weight_select !== 4'b0001) $display("FAIL reset_wsel: got %b want 0001", bus.weight_select); else passed++;
        total++; if (bus.M_Valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", bus.M_Valid); else passed++;
        total++; if (bus.Compute_Complete !== 1'b0) $display("FAIL reset_cc: got %b want 0", bus.Compute_Complete); else passed++;
        total++; if (bus.Conv_Complete !== 1'b0) $display("FAIL reset_conv: got %b want 0", bus.Conv_Complete); else passed++;
        total++; if (bus.fifo_out_data !== '0) $display("FAIL reset_data: got %h want 0", bus.fifo_out_data); else passed++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_weight_load();
        bus.Row_Num_Out_REG     = 11'd4;
        bus.Channel_Out_Num_REG = 8'd8;
        bus.M_Ready             = 1'b1;
        pulse_start();
        for (int k = 0; k < 33; k++) begin
            total++; if (bus.weight_addrb !== 6'(k)) $display("FAIL load_addr[%0d]: got %0d want %0d", k, bus.weight_addrb, k); else passed++;
            total++; if (bus.rd_en_fifo !== 1'b0) $display("FAIL load_rd_en[%0d]: got %b want 0", k, bus.rd_en_fifo); else passed++;
            @(negedge clk);
        end
        total++; if (bus.weight_addrb !== 6'd0) $display("FAIL load_addr_return: got %0d want 0", bus.weight_addrb); else passed++;
    endtask

    task automatic test_row_c8();
        run_image(30, 0, 4, 1);
        total++; if (n_rd !== 4) $display("FAIL c8_rd_count: got %0d want 4", n_rd); else passed++;
        total++; if (last_rd - first_rd !== 3) $display("FAIL c8_rd_span: got %0d want 3", last_rd - first_rd); else passed++;
        total++; if (first_mv - first_rd !== 6) $display("FAIL c8_latency: got %0d want 6", first_mv - first_rd); else passed++;
        total++; if (n_mv !== 4) $display("FAIL c8_mv_count: got %0d want 4", n_mv); else passed++;
        total++; if (last_mv - first_mv !== 3) $display("FAIL c8_mv_span: got %0d want 3", last_mv - first_mv); else passed++;
        total++; if (n_cc !== 1) $display("FAIL c8_cc_count: got %0d want 1", n_cc); else passed++;
        total++; if (n_conv !== 0) $display("FAIL c8_conv_count: got %0d want 0", n_conv); else passed++;
        total++; if (data_bad !== 0) $display("FAIL c8_data: got %0d bad words want 0", data_bad); else passed++;
    endtask

    task automatic test_backpressure();
        bus.M_Ready = 1'b0;
        run_image(12, 0, 4, 1);
        total++; if (n_rd !== 0) $display("FAIL bp_hold_rd: got %0d want 0", n_rd); else passed++;
        bus.M_Ready = 1'b1;
        run_image(30, 0, 0, 1);
        total++; if (first_rd !== 1) $display("FAIL bp_start_cycle: got %0d want 1", first_rd); else passed++;
        total++; if (n_rd !== 4) $display("FAIL bp_rd_count: got %0d want 4", n_rd); else passed++;
        total++; if (n_cc !== 1) $display("FAIL bp_cc_count: got %0d want 1", n_cc); else passed++;
        total++; if (data_bad !== 0) $display("FAIL bp_data: got %0d bad words want 0", data_bad); else passed++;
    endtask

    task automatic test_finish_image();
        run_image(200, 1, 8, 1);
        total++; if (done !== 1'b1) $display("FAIL fin_timeout: got %b want 1", done); else passed++;
        total++; if (n_cc !== 2) $display("FAIL fin_cc_count: got %0d want 2", n_cc); else passed++;
        total++; if (n_conv !== 1) $display("FAIL fin_conv_count: got %0d want 1", n_conv); else passed++;
        total++; if (n_mv !== 8) $display("FAIL fin_mv_count: got %0d want 8", n_mv); else passed++;
        total++; if (data_bad !== 0) $display("FAIL fin_data: got %0d bad words want 0", data_bad); else passed++;
    endtask

    task automatic test_c32_image();
        bus.Row_Num_Out_REG     = 11'd4;
        bus.Channel_Out_Num_REG = 8'd32;
        pulse_start();
        run_image(400, 1, 16, 4);
        total++; if (done !== 1'b1) $display("FAIL c32_timeout: got %b want 1", done); else passed++;
        total++; if (n_rd !== 16) $display("FAIL c32_rd_count: got %0d want 16", n_rd); else passed++;
        total++; if (ws_bad !== 0) $display("FAIL c32_wsel_seq: got %0d bad cycles want 0", ws_bad); else passed++;
        total++; if (n_mv !== 64) $display("FAIL c32_mv_count: got %0d want 64", n_mv); else passed++;
        total++; if (n_cc !== 4) $display("FAIL c32_cc_count: got %0d want 4", n_cc); else passed++;
        total++; if (n_conv !== 1) $display("FAIL c32_conv_count: got %0d want 1", n_conv); else passed++;
        total++; if (data_bad !== 0) $display("FAIL c32_data: got %0d bad words want 0", data_bad); else passed++;
    endtask

    task automatic test_fifo_bound();
        logic exp_sr;
        bus.Row_Num_Out_REG     = 11'd4;
        bus.Channel_Out_Num_REG = 8'd8;
        for (int k = 0; k < DEPTH + 1; k++) begin
            exp_sr = ((DEPTH - q.size()) >= 4);
            total++; if (bus.S_Ready !== exp_sr) $display("FAIL bound_s_ready[%0d]: got %b want %b", k, bus.S_Ready, exp_sr); else passed++;
            if (q.size() < DEPTH) q.push_back(seq_next);
            bus.S_Valid   = '1;
            bus.S_Feature = mk_word(seq_next);
            seq_next++;
            @(negedge clk);
        end
        bus.S_Valid = '0;
        total++; if (bus.S_Ready !== 1'b0) $display("FAIL bound_full_s_ready: got %b want 0", bus.S_Ready); else passed++;
        // 32x32 image pops exactly the 1024 words that were kept.
        bus.Row_Num_Out_REG = 11'd32;
        pulse_start();
        run_image(3000, 1, 0, 1);
        total++; if (done !== 1'b1) $display("FAIL bound_timeout: got %b want 1", done); else passed++;
        total++; if (n_rd !== 1024) $display("FAIL bound_rd_count: got %0d want 1024", n_rd); else passed++;
        total++; if (n_cc !== 32) $display("FAIL bound_cc_count: got %0d want 32", n_cc); else passed++;
        total++; if (data_bad !== 0) $display("FAIL bound_order: got %0d bad words want 0", data_bad); else passed++;
        total++; if (bus.S_Ready !== 1'b1) $display("FAIL bound_empty_s_ready: got %b want 1", bus.S_Ready); else passed++;
    endtask

    task automatic test_reset_mid_compute();
        bus.Row_Num_Out_REG     = 11'd4;
        bus.Channel_Out_Num_REG = 8'd32;
        pulse_start();
        run_image(200, 2, 4, 4);
        total++; if (done !== 1'b1) $display("FAIL mid_reach_compute: got %b want 1", done); else passed++;
        run_image(2, 0, 0, 4);
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.rd_en_fifo !== 1'b0) $display("FAIL mid_rst_rd_en: got %b want 0", bus.rd_en_fifo); else passed++;
        total++; if (bus.weight_select !== 4'b0001) $display("FAIL mid_rst_wsel: got %b want 0001", bus.weight_select); else passed++;
        total++; if (bus.M_Valid !== 1'b0) $display("FAIL mid_rst_m_valid: got %b want 0", bus.M_Valid); else passed++;
        total++; if (bus.fifo_out_data !== '0) $display("FAIL mid_rst_data: got %h want 0", bus.fifo_out_data); else passed++;
        total++; if (bus.weight_addrb !== 6'd0) $display("FAIL mid_rst_addr: got %0d want 0", bus.weight_addrb); else passed++;
        rst = 1'b1;
        q.delete();
        pend = 1'b0;
        @(negedge clk);
        pulse_start();
        run_image(400, 1, 16, 4);
        total++; if (done !== 1'b1) $display("FAIL mid_rerun_timeout: got %b want 1", done); else passed++;
        total++; if (n_rd !== 16) $display("FAIL mid_rerun_rd: got %0d want 16", n_rd); else passed++;
        total++; if (n_mv !== 64) $display("FAIL mid_rerun_mv: got %0d want 64", n_mv); else passed++;
        total++; if (n_cc !== 4) $display("FAIL mid_rerun_cc: got %0d want 4", n_cc); else passed++;
        total++; if (data_bad !== 0) $display("FAIL mid_rerun_data: got %0d bad words want 0", data_bad); else passed++;
    endtask

    task automatic test_zero_rows();
        bus.Row_Num_Out_REG     = 11'd0;
        bus.Channel_Out_Num_REG = 8'd8;
        pulse_start();
        run_image(100, 1, 0, 1);
        total++; if (done !== 1'b1) $display("FAIL r0_conv_seen: got %b want 1", done); else passed++;
        total++; if (n_mv !== 0) $display("FAIL r0_mv_count: got %0d want 0", n_mv); else passed++;
        total++; if (n_rd !== 0) $display("FAIL r0_rd_count: got %0d want 0", n_rd); else passed++;
        total++; if (n_cc !== 0) $display("FAIL r0_cc_count: got %0d want 0", n_cc); else passed++;
    endtask

    initial begin
        rst                     = 1'b0;
        bus.Start               = 1'b0;
        bus.Row_Num_Out_REG     = '0;
        bus.Channel_Out_Num_REG = '0;
        bus.S_Valid             = '0;
        bus.S_Feature           = '0;
        bus.M_Ready             = 1'b0;
        @(negedge clk);
        test_reset();
        test_weight_load();
        test_row_c8();
        test_backpressure();
        test_finish_image();
        test_c32_image();
        test_fifo_bound();
        test_reset_mid_compute();
        test_zero_rows();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
